// File: rtl/bfp_pkg.sv
// Shared types and shifter-control constants for the block-floating-point
// alignment scheduler.
package bfp_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    ALIGN   = 1'b1
  } state_t;

  localparam int SH_REV_BIT = 4;
  localparam int SH_AMT_W   = 4;
  localparam int MAX_SHIFT  = 15;

endpackage

// File: rtl/bfp_blk_buf.sv
// Block buffer: BLK x (W+EW) register file, one synchronous write port and
// one asynchronous read port. Contents are not reset (don't-care after reset).
module bfp_blk_buf #(
  parameter int W   = 32,
  parameter int EW  = 8,
  parameter int BLK = 16,
  localparam int AW = $clog2(BLK),
  localparam int DW = W + EW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [BLK];

  // Storage write
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/bfp_shift_sched.sv
// BFP alignment scheduler: collects a block, tracks the max exponent, then
// aligns each mantissa through an external shifter. Optional macro: BFP_ROUND_EN.
module bfp_shift_sched
  import bfp_pkg::*;
#(
  parameter int W   = 32,
  parameter int EW  = 8,
  parameter int BLK = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_mant,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_mant,
  output logic [EW-1:0] out_exp,
  output logic          out_last,
  output logic [W-1:0]  sh_up_dat,
  output logic [4:0]    sh_ctrl,
  input  logic [W-1:0]  sh_dn_dat
);

  localparam int AW = $clog2(BLK);

  state_t          state_r;
  state_t          state_next_s;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [EW-1:0]   max_exp_r;
  logic [EW-1:0]   blk_exp_r;
  logic [EW-1:0]   max_next_s;
  logic [W+EW-1:0] rd_data_s;
  logic [W-1:0]    rd_mant_s;
  logic [EW-1:0]   rd_exp_s;
  logic [EW-1:0]   d_s;
  logic            wr_en_s;
  logic            wr_last_s;
  logic            rd_last_s;
  logic            issue_s;
  logic            underflow_s;
  logic [W-1:0]    result_s;

  assign in_ready    = (state_r == COLLECT);
  assign wr_en_s     = in_valid && in_ready;
  assign wr_last_s   = (wr_ptr_r == AW'(BLK - 1));
  assign rd_last_s   = (rd_ptr_r == AW'(BLK - 1));
  assign issue_s     = (state_r == ALIGN) && (!out_valid || out_ready);
  assign rd_mant_s   = rd_data_s[W+EW-1:EW];
  assign rd_exp_s    = rd_data_s[EW-1:0];
  // blk_exp is the block maximum, so this subtraction never goes negative
  assign d_s         = blk_exp_r - rd_exp_s;
  assign underflow_s = (d_s > EW'(MAX_SHIFT));

  bfp_blk_buf #(
    .W   (W),
    .EW  (EW),
    .BLK (BLK)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wr_ptr_r),
    .wdata ({in_mant, in_exp}),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  // Running maximum; the first element of a block restarts it
  always_comb begin
    max_next_s = max_exp_r;
    if (wr_ptr_r == {AW{1'b0}}) begin
      max_next_s = in_exp;
    end else if (in_exp > max_exp_r) begin
      max_next_s = in_exp;
    end else begin
      max_next_s = max_exp_r;
    end
  end

  // Shifter drive: only active in ALIGN, clamped to the largest shift on underflow
  always_comb begin
    sh_up_dat = {W{1'b0}};
    sh_ctrl   = 5'b00000;
    if (state_r == ALIGN) begin
      sh_up_dat = rd_mant_s;
      if (underflow_s) begin
        sh_ctrl = 5'b01111;
      end else begin
        sh_ctrl = {1'b0, d_s[SH_AMT_W-1:0]};
      end
    end else begin
      sh_up_dat = {W{1'b0}};
      sh_ctrl   = 5'b00000;
    end
  end

`ifdef BFP_ROUND_EN
  logic [W-1:0] guard_vec_s;
  logic         guard_s;

  // Round half up on the last shifted-out bit, saturating at all-ones
  always_comb begin
    result_s    = {W{1'b0}};
    guard_vec_s = rd_mant_s >> (d_s[SH_AMT_W-1:0] - 4'd1);
    guard_s     = 1'b0;
    if (underflow_s) begin
      result_s = {W{1'b0}};
    end else if (d_s == {EW{1'b0}}) begin
      result_s = sh_dn_dat;
    end else begin
      guard_s = guard_vec_s[0];
      if (guard_s && (&sh_dn_dat)) begin
        result_s = sh_dn_dat;
      end else begin
        result_s = sh_dn_dat + {{(W-1){1'b0}}, guard_s};
      end
    end
  end
`else
  // Plain truncation; full underflow forces zero
  always_comb begin
    result_s = {W{1'b0}};
    if (underflow_s) begin
      result_s = {W{1'b0}};
    end else begin
      result_s = sh_dn_dat;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      COLLECT: begin
        if (wr_en_s && wr_last_s) begin
          state_next_s = ALIGN;
        end else begin
          state_next_s = COLLECT;
        end
      end
      ALIGN: begin
        if (issue_s && rd_last_s) begin
          state_next_s = COLLECT;
        end else begin
          state_next_s = ALIGN;
        end
      end
      default: state_next_s = COLLECT;
    endcase
  end

  // Pointers, exponent tracking and registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      max_exp_r <= {EW{1'b0}};
      blk_exp_r <= {EW{1'b0}};
      out_valid <= 1'b0;
      out_mant  <= {W{1'b0}};
      out_exp   <= {EW{1'b0}};
      out_last  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r  <= wr_ptr_r + AW'(1);
        max_exp_r <= max_next_s;
        if (wr_last_s) begin
          blk_exp_r <= max_next_s;
        end
      end
      // The final output of a block may linger into the next COLLECT phase
      if (issue_s) begin
        out_mant  <= result_s;
        out_exp   <= blk_exp_r;
        out_valid <= 1'b1;
        out_last  <= rd_last_s;
        rd_ptr_r  <= rd_ptr_r + AW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bfp_shift_sched.sv
// Directed bench for bfp_shift_sched (BLK=16) with a behavioural right-shifter
// standing in for the external barrel_shifter.
module tb_bfp_shift_sched;

  typedef logic [31:0] mv_t [16];
  typedef logic [7:0]  ev_t [16];
  typedef logic [4:0]  cv_t [16];

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mant;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_last;
  logic [31:0] sh_up_dat;
  logic [4:0]  sh_ctrl;
  logic [31:0] sh_dn_dat;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  mv_t m, x;
  ev_t e;
  cv_t c;

  always #5 clk = ~clk;

  assign sh_dn_dat = sh_ctrl[4] ? 32'h0 : (sh_up_dat >> sh_ctrl[3:0]);

  bfp_shift_sched #(.W(32), .EW(8), .BLK(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_last  (out_last),
    .sh_up_dat (sh_up_dat),
    .sh_ctrl   (sh_ctrl),
    .sh_dn_dat (sh_dn_dat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] mant, input logic [7:0] ex);
    chk("in_ready_before_push", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b1;
    in_mant  = mant;
    in_exp   = ex;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_block(input string nm, input mv_t mm, input ev_t ee, input cv_t cc,
                           input mv_t xx, input logic [7:0] bexp);
    for (int i = 0; i < 16; i++) push(mm[i], ee[i]);
    chk({nm, "_lat_valid0"}, {31'b0, out_valid}, 32'h0);
    chk({nm, "_in_ready0"}, {31'b0, in_ready}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_ctrl%0d", nm, i), {27'b0, sh_ctrl}, {27'b0, cc[i]});
      tick();
      chk($sformatf("%s_valid%0d", nm, i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("%s_mant%0d", nm, i), out_mant, xx[i]);
      chk($sformatf("%s_exp%0d", nm, i), {24'b0, out_exp}, {24'b0, bexp});
      chk($sformatf("%s_last%0d", nm, i), {31'b0, out_last}, (i == 15) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mant   = 32'h0;
    in_exp    = 8'h0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_mant", out_mant, 32'h0);
    chk("rst_out_exp", {24'b0, out_exp}, 32'h0);
    chk("rst_out_last", {31'b0, out_last}, 32'h0);
    chk("rst_sh_up", sh_up_dat, 32'h0);
    chk("rst_sh_ctrl", {27'b0, sh_ctrl}, 32'h0);

    // Uniform block
    for (int i = 0; i < 16; i++) begin
      m[i] = 32'h0000_1000; e[i] = 8'd10; c[i] = 5'd0; x[i] = 32'h0000_1000;
    end
    run_block("uni", m, e, c, x, 8'd10);

    // Mixed exponents 20,18,20,5 then 20s
    for (int i = 0; i < 16; i++) begin
      m[i] = 32'h8000_0000; e[i] = 8'd20; c[i] = 5'd0; x[i] = 32'h8000_0000;
    end
    e[1] = 8'd18; c[1] = 5'd2;  x[1] = 32'h2000_0000;
    e[3] = 8'd5;  c[3] = 5'd15; x[3] = 32'h0001_0000;
    run_block("mix", m, e, c, x, 8'd20);

    // Underflow: d=20 on element 1
    for (int i = 0; i < 16; i++) begin
      m[i] = 32'h8000_0000; e[i] = 8'd40; c[i] = 5'd0; x[i] = 32'h8000_0000;
    end
    e[1] = 8'd20; c[1] = 5'b01111; x[1] = 32'h0;
    run_block("unf", m, e, c, x, 8'd40);

    // Rounding vs truncation at d=1
    for (int i = 0; i < 16; i++) begin
      m[i] = 32'h0000_0004; e[i] = 8'd10; c[i] = 5'd1; x[i] = 32'h0000_0002;
    end
    m[0] = 32'h0000_0010; e[0] = 8'd11; c[0] = 5'd0; x[0] = 32'h0000_0010;
    m[1] = 32'h0000_0003;
    m[2] = 32'hFFFF_FFFF;
`ifdef BFP_ROUND_EN
    x[1] = 32'h0000_0002;
    x[2] = 32'h8000_0000;
`else
    x[1] = 32'h0000_0001;
    x[2] = 32'h7FFF_FFFF;
`endif
    run_block("rnd", m, e, c, x, 8'd11);

    // Backpressure mid-ALIGN, then a second block collected behind a stalled last output
    for (int i = 0; i < 16; i++) push(32'((i + 1) * 16), 8'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_pre_mant%0d", i), out_mant, 32'((i + 1) * 16));
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_hold_valid%0d", k), {31'b0, out_valid}, 32'h1);
      chk($sformatf("bp_hold_mant%0d", k), out_mant, 32'h30);
      chk($sformatf("bp_hold_last%0d", k), {31'b0, out_last}, 32'h0);
      chk($sformatf("bp_hold_shup%0d", k), sh_up_dat, 32'h40);
    end
    out_ready = 1'b1;
    for (int i = 3; i < 16; i++) begin
      tick();
      chk($sformatf("bp_post_mant%0d", i), out_mant, 32'((i + 1) * 16));
      chk($sformatf("bp_post_last%0d", i), {31'b0, out_last}, (i == 15) ? 32'h1 : 32'h0);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(32'h0000_1000 + 32'(i), 8'd3);
    tick();
    chk("b2b_hold_valid", {31'b0, out_valid}, 32'h1);
    chk("b2b_hold_mant", out_mant, 32'h100);
    chk("b2b_hold_last", {31'b0, out_last}, 32'h1);
    chk("b2b_hold_exp", {24'b0, out_exp}, 32'h7);
    chk("b2b_shup", sh_up_dat, 32'h0000_1000);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("b2b_valid%0d", i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("b2b_mant%0d", i), out_mant, 32'h0000_1000 + 32'(i));
      chk($sformatf("b2b_exp%0d", i), {24'b0, out_exp}, 32'h3);
      chk($sformatf("b2b_last%0d", i), {31'b0, out_last}, (i == 15) ? 32'h1 : 32'h0);
    end
    tick();
    chk("b2b_drained", {31'b0, out_valid}, 32'h0);

    // Reset after 7 partial inputs with a large exponent
    for (int i = 0; i < 7; i++) push(32'h0000_FFFF, 8'd200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      m[i] = 32'h0000_0200; e[i] = 8'd9; c[i] = 5'd0; x[i] = 32'h0000_0200;
    end
    run_block("fresh", m, e, c, x, 8'd9);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bfp_shift_sched.md
Name: bfp_shift_sched

Overview:
- Block-floating-point alignment scheduler that time-multiplexes one external barrel_shifter instance (W-bit, 5-bit ctrl) across a block of BLK mantissa/exponent pairs.
- Collect phase: buffers one block and tracks the maximum exponent.
- Align phase: feeds each mantissa through the shifter, right-shifted by (max_exp - exp_i), and streams out aligned mantissas tagged with the shared exponent.
- Sits between the quantiser front-end and the BFP MAC array.

Parameters:
- W, 32: mantissa width; must match the shifter width.
- EW, 8: exponent width (unsigned, biased).
- BLK, 16: elements per block; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  high only in COLLECT.
- in_mant  in  W  unsigned mantissa magnitude.
- in_exp  in  EW  element exponent.
- out_valid  out  1  aligned element valid.
- out_ready  in  1  downstream accept.
- out_mant  out  W  aligned mantissa.
- out_exp  out  EW  shared (max) exponent of the current block.
- out_last  out  1  high with the BLK-th output of a block.
- sh_up_dat  out  W  to shifter up_dat.
- sh_ctrl  out  5  to shifter ctrl: bit 4 = reverse (always 0 here), bits 3:0 = right-shift amount.
- sh_dn_dat  in  W  from shifter dn_dat; the shifter is combinational.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to COLLECT; wr_ptr, rd_ptr and max_exp clear to 0.
  - Outputs reset to: in_ready=1, out_valid=0, out_mant=0, out_exp=0, out_last=0, sh_up_dat=0, sh_ctrl=0.
  - Reset mid-block discards the partial block and any pending output; buffer contents become don't-care.
- COLLECT state:
  - On in_valid&&in_ready: buf[wr_ptr]={in_mant,in_exp}, wr_ptr++.
  - max_exp takes in_exp when wr_ptr==0; otherwise max_exp=max(max_exp,in_exp).
  - When the BLK-th element is written: latch max_exp into blk_exp, wr_ptr wraps to 0, go to ALIGN. in_ready drops the next cycle.
- ALIGN state:
  - issue = (!out_valid || out_ready).
  - sh_up_dat/sh_ctrl are driven combinationally from buf[rd_ptr] every cycle in ALIGN; both are 0 outside ALIGN.
  - d = blk_exp - exp[rd_ptr], unsigned EW bits, never negative by construction.
  - If d ≤ 15: sh_ctrl = {1'b0, d[3:0]}.
  - If d > 15: sh_ctrl = 5'b01111 and the captured result is forced to 0 (full underflow).
  - On issue: out_mant <= result (from sh_dn_dat), out_exp <= blk_exp, out_valid <= 1, out_last <= (rd_ptr==BLK-1), rd_ptr++.
  - The issue that consumes rd_ptr==BLK-1 wraps rd_ptr to 0 and returns to COLLECT.
- Latency: first aligned output appears 2 cycles after the BLK-th input accept.
- Throughput: 1 element/clk with out_ready held high.
- out_valid && !out_ready:
  - out_mant, out_exp and out_last are held stable.
  - rd_ptr does not advance; the sh_* outputs continue to reflect buf[rd_ptr].
- After the final issue: out_valid stays up until accepted, even though the state is already COLLECT. The next block may be collected concurrently. out_exp is held from the old block until the next issue.
- Equal exponents give d=0, so the mantissa passes unshifted.
- Back-to-back blocks: no idle cycles are required other than the BLK collect cycles.

Optional Feature:
- Macro: BFP_ROUND_EN.
- Defined: round-half-up on the shifted-out bits.
  - For 1 ≤ d ≤ 15, guard = mant[d-1], and out_mant = sh_dn_dat + guard, saturating at all-ones.
  - For d = 0, no rounding is applied.
  - For d > 15, the result is still 0.
  - Adds no extra latency.
- Undefined: plain truncation as described in Behaviour.

Decomposition:
- Package bfp_pkg holds:
  - state enum {COLLECT, ALIGN};
  - SH_REV_BIT=4;
  - SH_AMT_W=4;
  - MAX_SHIFT=15.
- One sub-module: bfp_blk_buf, a BLK×(W+EW) register file with 1 synchronous write port and 1 asynchronous read port.
- The barrel_shifter is instantiated by the parent, not inside this block.

Test Plan:
- Uniform block: 16 elements, mant=0x0000_1000, exp=10 → 16 outputs of 0x0000_1000, out_exp=10, out_last only on the 16th; first output 2 cycles after the last accept.
- Mixed exponents, exps 20,18,20,5 (BLK=4), mants all 0x8000_0000 → sh_ctrl = 0,2,0,15; outputs 0x80000000, 0x20000000, 0x80000000, 0x00010000; out_exp=20.
- Underflow, BLK=4: exps 40,20,40,40 → d=20 on element 1 → out_mant=0.
- Backpressure: out_ready low for 5 cycles mid-ALIGN → out_mant/out_last stable, rd_ptr frozen, no element lost or duplicated. A second block collected while the last output is stalled → correct sequence afterwards.
- Reset after 7 of 16 inputs, then 16 fresh inputs → only the fresh block appears; max_exp is not polluted by the discarded elements.
- BFP_ROUND_EN: mant=0x0000_0003, d=1 → out 0x2.
- BFP_ROUND_EN: mant=0xFFFF_FFFF, d=1 → out 0x8000_0000 (guard adds 1 to 0x7FFF_FFFF).
- Without BFP_ROUND_EN: mant=0x0000_0003, d=1 → out 0x1.
